lwe_decrypt: RTL and testbench

- Streaming LWE decryption stage. It consumes the ciphertext vector that the encrypt stage produces, one element per beat: c0 first, then c1..c_DIMENSION.
- It computes phase = c0 − Σ c_i·s_i mod CIPHERTEXT_MODULUS against a held secret key.
- It then rounds the phase to a PLAINTEXT_WIDTH-bit message.
- It sits at the receive end of the enclave datapath and is the round-trip checker for encrypt.

---
 rtl/lwe_decrypt_if.sv | 31 +++
 rtl/lwe_decrypt.sv | 140 ++++++++++++++
 tb/tb_lwe_decrypt.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/lwe_decrypt_if.sv
// Handshake bundle between the ciphertext source, the decrypt stage and the
// plaintext sink. The slave side is the decrypt stage itself.
interface lwe_decrypt_if #(
    parameter int CIPHERTEXT_WIDTH = 10,
    parameter int PLAINTEXT_WIDTH  = 6
);
    logic                        ct_valid;
    logic                        ct_ready;
    logic [CIPHERTEXT_WIDTH-1:0] ct_data;
    logic                        pt_valid;
    logic                        pt_ready;
    logic [PLAINTEXT_WIDTH-1:0]  plaintext;

    modport master (
        output ct_valid,
        output ct_data,
        output pt_ready,
        input  ct_ready,
        input  pt_valid,
        input  plaintext
    );

    modport slave (
        input  ct_valid,
        input  ct_data,
        input  pt_ready,
        output ct_ready,
        output pt_valid,
        output plaintext
    );
endinterface

// File: rtl/lwe_decrypt.sv
// Streaming LWE decryption: takes c0, c1..cn one element per beat, forms
// phase = c0 - sum(c_i * s_i) mod q and rounds it to a p-ary message.
// q and p are powers of two, so every modulo is plain W-bit wraparound.
module lwe_decrypt #(
    parameter int PLAINTEXT_MODULUS  = 64,
    parameter int PLAINTEXT_WIDTH    = 6,
    parameter int CIPHERTEXT_MODULUS = 1024,
    parameter int CIPHERTEXT_WIDTH   = 10,
    parameter int DIMENSION          = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [DIMENSION*CIPHERTEXT_WIDTH-1:0] secretkey,
    lwe_decrypt_if.slave                          bus
);
    localparam int W     = CIPHERTEXT_WIDTH;
    localparam int PW    = PLAINTEXT_WIDTH;
    localparam int IW    = $clog2(DIMENSION + 1);
    localparam int SHIFT = W - PW;
    // Half a plaintext step (q/2p) turns the truncating shift into round-to-nearest.
    localparam logic [W-1:0]  ROUND_OFFSET = W'(CIPHERTEXT_MODULUS / (2 * PLAINTEXT_MODULUS));
    localparam logic [IW-1:0] LAST_IDX     = IW'(DIMENSION);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_next_s;
    logic [W-1:0]   acc_r;
    logic [W-1:0]   acc_next_s;
    logic [IW-1:0]  idx_r;
    logic [IW-1:0]  idx_next_s;
    logic           ct_ready_r;
    logic           pt_valid_r;
    logic [PW-1:0]  plaintext_r;
    logic           load_pt_s;
    logic           beat_s;
    logic [W-1:0]   key_sel_s;
    logic [W-1:0]   prod_lo_s;

    // Round the phase to the nearest message; the add wraps so a phase just
    // below q lands on message 0.
    function automatic logic [PW-1:0] round_phase(input logic [W-1:0] phase);
        logic [W-1:0] biased;
        biased = phase + ROUND_OFFSET;
        return PW'(biased >> SHIFT);
    endfunction

    assign beat_s = bus.ct_valid && ct_ready_r;

    // Pick s_idx out of the packed key (s_i lives at bits [i*W-1 -: W]).
    always_comb begin
        key_sel_s = {W{1'b0}};
        for (int i = 1; i <= DIMENSION; i++) begin
            if (idx_r == IW'(i)) begin
                key_sel_s = secretkey[i*W-1 -: W];
            end else begin
                key_sel_s = key_sel_s;
            end
        end
    end

    // Only the low W bits of the 2W product matter modulo q, so compute just those.
    assign prod_lo_s = bus.ct_data * key_sel_s;

    // Next-state and datapath update for the IDLE/ACCUM/DONE sequencer.
    always_comb begin
        state_next_s = state_r;
        acc_next_s   = acc_r;
        idx_next_s   = idx_r;
        load_pt_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (beat_s) begin
                    acc_next_s   = bus.ct_data;
                    idx_next_s   = IW'(1);
                    state_next_s = ACCUM;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCUM: begin
                if (beat_s) begin
                    acc_next_s = acc_r - prod_lo_s;
                    idx_next_s = idx_r + IW'(1);
                    if (idx_r == LAST_IDX) begin
                        state_next_s = DONE;
                        load_pt_s    = 1'b1;
                    end else begin
                        state_next_s = ACCUM;
                    end
                end else begin
                    state_next_s = ACCUM;
                end
            end
            DONE: begin
                if (bus.pt_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
                acc_next_s   = {W{1'b0}};
                idx_next_s   = {IW{1'b0}};
            end
        endcase
    end

    // State, accumulator and registered handshake outputs; reset drops any partial work.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            acc_r       <= {W{1'b0}};
            idx_r       <= {IW{1'b0}};
            ct_ready_r  <= 1'b0;
            pt_valid_r  <= 1'b0;
            plaintext_r <= {PW{1'b0}};
        end else begin
            state_r    <= state_next_s;
            acc_r      <= acc_next_s;
            idx_r      <= idx_next_s;
            ct_ready_r <= (state_next_s != DONE);
            pt_valid_r <= (state_next_s == DONE);
            if (load_pt_s) begin
                plaintext_r <= round_phase(acc_next_s);
            end else begin
                plaintext_r <= plaintext_r;
            end
        end
    end

    assign bus.ct_ready  = ct_ready_r;
    assign bus.pt_valid  = pt_valid_r;
    assign bus.plaintext = plaintext_r;
endmodule

// File: tb/tb_lwe_decrypt.sv
// Directed bench for lwe_decrypt (q=1024, p=64, n=1). Stimulus pushes the
// hand-computed plaintext into a scoreboard queue; a monitor pops and compares
// on every plaintext handshake.
module tb_lwe_decrypt;
    logic       clk;
    logic       rst;
    logic [9:0] secretkey;

    lwe_decrypt_if #(.CIPHERTEXT_WIDTH(10), .PLAINTEXT_WIDTH(6)) bus ();

    lwe_decrypt dut (
        .clk       (clk),
        .rst       (rst),
        .secretkey (secretkey),
        .bus       (bus)
    );

    int       pass_cnt = 0;
    int       total_cnt = 0;
    int       push_cnt = 0;
    int       out_cnt = 0;
    int       sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        total_cnt++;
        if (actual == expected) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic expect_pt(input int value);
        sb.push_back(value);
        push_cnt++;
    endtask

    // Present one element and hold it until an edge where ct_ready was high.
    task automatic send_beat(input int data, output int waits);
        logic rdy;
        waits = 0;
        bus.ct_valid = 1'b1;
        bus.ct_data  = 10'(data);
        do begin
            @(negedge clk);
            rdy = bus.ct_ready;
            @(posedge clk);
            #1;
            waits++;
        end while (!rdy && waits < 100);
        if (!rdy) begin
            check("ct_accept_timeout", 0, 1);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard monitor: every plaintext handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.pt_valid && bus.pt_ready) begin
            out_cnt++;
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_output actual=%0d expected=none", bus.plaintext);
            end else begin
                check("plaintext", int'(bus.plaintext), sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        rst          = 1'b1;
        secretkey    = 10'd5;
        bus.ct_valid = 1'b0;
        bus.ct_data  = 10'd0;
        bus.pt_ready = 1'b1;

        // Reset state
        idle_cycles(2);
        check("rst_ct_ready", int'(bus.ct_ready), 0);
        check("rst_pt_valid", int'(bus.pt_valid), 0);
        check("rst_plaintext", int'(bus.plaintext), 0);
        rst = 1'b0;
        idle_cycles(1);
        check("ct_ready_after_rst", int'(bus.ct_ready), 1);

        // Vector {535,100}, s1=5 -> 2; one-edge latency, single-cycle pt_valid
        expect_pt(2);
        send_beat(535, w);
        send_beat(100, w);
        bus.ct_valid = 1'b0;
        check("latency_pt_valid", int'(bus.pt_valid), 1);
        check("latency_plaintext", int'(bus.plaintext), 2);
        idle_cycles(1);
        check("pt_valid_one_cycle", int'(bus.pt_valid), 0);

        // s1=7, {31,300}: product wraps to 52, phase 1003 -> 63
        secretkey = 10'd7;
        expect_pt(63);
        send_beat(31, w);
        send_beat(300, w);
        bus.ct_valid = 1'b0;
        idle_cycles(2);

        // s1=5, {496,100}: phase 1020, rounding wraps -> 0
        secretkey = 10'd5;
        expect_pt(0);
        send_beat(496, w);
        send_beat(100, w);
        bus.ct_valid = 1'b0;
        idle_cycles(2);

        // Gaps between beats, then 3 cycles of backpressure
        expect_pt(2);
        send_beat(535, w);
        bus.ct_valid = 1'b0;
        idle_cycles(2);
        bus.pt_ready = 1'b0;
        send_beat(100, w);
        bus.ct_data = 10'd999;
        for (int i = 0; i < 3; i++) begin
            check("bp_ct_ready", int'(bus.ct_ready), 0);
            check("bp_pt_valid", int'(bus.pt_valid), 1);
            check("bp_plaintext", int'(bus.plaintext), 2);
            idle_cycles(1);
        end
        expect_pt(2);
        bus.ct_data  = 10'd535;
        bus.pt_ready = 1'b1;
        idle_cycles(1);
        check("post_hs_ct_ready", int'(bus.ct_ready), 1);
        check("post_hs_pt_valid", int'(bus.pt_valid), 0);
        send_beat(535, w);
        check("post_hs_accept_cycles", w, 1);
        send_beat(100, w);
        bus.ct_valid = 1'b0;
        idle_cycles(3);

        // Reset after c0 accepted: partial vector discarded
        secretkey = 10'd7;
        send_beat(535, w);
        bus.ct_valid = 1'b0;
        rst = 1'b1;
        idle_cycles(1);
        check("midrst_pt_valid", int'(bus.pt_valid), 0);
        check("midrst_plaintext", int'(bus.plaintext), 0);
        check("midrst_ct_ready", int'(bus.ct_ready), 0);
        rst = 1'b0;
        idle_cycles(1);
        check("postrst_pt_valid", int'(bus.pt_valid), 0);
        check("postrst_plaintext", int'(bus.plaintext), 0);
        expect_pt(63);
        send_beat(31, w);
        send_beat(300, w);
        bus.ct_valid = 1'b0;
        idle_cycles(3);

        // Back-to-back vectors with ct_valid held high
        secretkey = 10'd5;
        expect_pt(2);
        expect_pt(63);
        send_beat(535, w);
        send_beat(100, w);
        secretkey = 10'd7;
        send_beat(31, w);
        check("b2b_next_c0_cycles", w, 2);
        send_beat(300, w);
        check("b2b_c1_cycles", w, 1);
        bus.ct_valid = 1'b0;

        for (int i = 0; i < 50 && sb.size() != 0; i++) begin
            idle_cycles(1);
        end
        idle_cycles(2);
        check("scoreboard_drained", sb.size(), 0);
        check("output_count", out_cnt, push_cnt);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
